// File: rtl/regwb_arb.sv
// regwb_arb: register-file write-port arbiter that merges pipeline writeback with buffered long-latency results.
// Define REGWB_STATS_EN to build the cnt_lu_wr / cnt_kill statistics counters; otherwise both outputs are tied to 0.
module regwb_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pl_regwrite,
  input  logic [4:0]  pl_wrreg,
  input  logic [31:0] pl_wrdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wrreg,
  input  logic [31:0] lu_wrdata,
  output logic        lu_ready,
  output logic        regwrite,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata,
  output logic [31:0] pend,
  output logic        stall_req,
  output logic [31:0] cnt_lu_wr,
  output logic [31:0] cnt_kill
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [SW-1:0]    r_starve;

  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_push;
  logic             w_push_dead;
  logic             w_pop;
  logic             w_head_live;
  logic [AW-1:0]    w_widx;
  logic [AW-1:0]    w_ridx;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_live_nxt;

  assign w_widx      = r_wptr[AW-1:0];
  assign w_ridx      = r_rptr[AW-1:0];
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  assign lu_ready    = !w_full;
  assign w_busy      = pl_regwrite && (pl_wrreg != 5'd0);
  assign w_push      = lu_valid && lu_ready && (lu_wrreg != 5'd0);
  // A same-cycle pipeline write to the same register is younger, so the pushed value is born dead.
  assign w_push_dead = w_busy && (lu_wrreg == pl_wrreg);
  assign w_pop       = !w_busy && !w_empty;
  assign w_head_live = r_live[w_ridx];

  // Live bits of unoccupied slots are always 0, so the kill match needs no occupancy window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = w_busy && r_live[i] && (r_reg[i] == pl_wrreg);
    end
  end

  always_comb begin
    w_live_nxt = r_live & ~w_kill;
    if (w_pop)  w_live_nxt[w_ridx] = 1'b0;
    if (w_push) w_live_nxt[w_widx] = !w_push_dead;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) pend[r_reg[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  // NOTE: the payload array has no reset; occupancy is fully described by the pointers and live bits.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[w_widx]  <= lu_wrreg;
      r_data[w_widx] <= lu_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_live <= '0;
    end else begin
      r_live <= w_live_nxt;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve < SW'(STARVE_MAX)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign stall_req = (r_starve >= SW'(STARVE_MAX));

  // Address and data hold when the slot is idle or a dead head is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite <= 1'b0;
      wrreg    <= '0;
      wrdata   <= '0;
    end else if (w_busy) begin
      regwrite <= 1'b1;
      wrreg    <= pl_wrreg;
      wrdata   <= pl_wrdata;
    end else if (w_pop && w_head_live) begin
      regwrite <= 1'b1;
      wrreg    <= r_reg[w_ridx];
      wrdata   <= r_data[w_ridx];
    end else begin
      regwrite <= 1'b0;
    end
  end

`ifdef REGWB_STATS_EN
  logic [31:0]   r_cnt_lu_wr;
  logic [31:0]   r_cnt_kill;
  logic [AW+1:0] w_kill_num;

  always_comb begin
    w_kill_num = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill_num = w_kill_num + {{(AW+1){1'b0}}, w_kill[i]};
    end
    if (w_push && w_push_dead) w_kill_num = w_kill_num + (AW+2)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_lu_wr <= '0;
      r_cnt_kill  <= '0;
    end else begin
      if (w_pop && w_head_live) r_cnt_lu_wr <= r_cnt_lu_wr + 32'd1;
      r_cnt_kill <= r_cnt_kill + 32'(w_kill_num);
    end
  end

  assign cnt_lu_wr = r_cnt_lu_wr;
  assign cnt_kill  = r_cnt_kill;
`else
  assign cnt_lu_wr = '0;
  assign cnt_kill  = '0;
`endif

endmodule

// File: tb/tb_regwb_arb.sv
// tb_regwb_arb: directed bench for regwb_arb; expected register writes go into a scoreboard queue
// that a negedge monitor drains whenever regwrite is seen, plus direct checks of pend/ready/stall/counters.
module tb_regwb_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        pl_regwrite;
  logic [4:0]  pl_wrreg;
  logic [31:0] pl_wrdata;
  logic        lu_valid;
  logic [4:0]  lu_wrreg;
  logic [31:0] lu_wrdata;
  logic        lu_ready;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic [31:0] pend;
  logic        stall_req;
  logic [31:0] cnt_lu_wr;
  logic [31:0] cnt_kill;

`ifdef REGWB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  regwb_arb #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pl_regwrite(pl_regwrite),
    .pl_wrreg   (pl_wrreg),
    .pl_wrdata  (pl_wrdata),
    .lu_valid   (lu_valid),
    .lu_wrreg   (lu_wrreg),
    .lu_wrdata  (lu_wrdata),
    .lu_ready   (lu_ready),
    .regwrite   (regwrite),
    .wrreg      (wrreg),
    .wrdata     (wrdata),
    .pend       (pend),
    .stall_req  (stall_req),
    .cnt_lu_wr  (cnt_lu_wr),
    .cnt_kill   (cnt_kill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pl_regwrite = 1'b0;
    pl_wrreg    = '0;
    pl_wrdata   = '0;
    lu_valid    = 1'b0;
    lu_wrreg    = '0;
    lu_wrdata   = '0;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{r: r, d: d});
  endtask

  // Monitor: every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got reg=%0d data=%h, expected no write", wrreg, wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (wrreg !== mon_e.r || wrdata !== mon_e.d) begin
          n_fail++;
          $display("FAIL write_order: got reg=%0d data=%h, expected reg=%0d data=%h",
                   wrreg, wrdata, mon_e.r, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_regwrite", {31'd0, regwrite}, 32'd0);
    check("rst_wrreg", {27'd0, wrreg}, 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    check("rst_pend", pend, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_cnt_lu_wr", cnt_lu_wr, 32'd0);
    check("rst_cnt_kill", cnt_kill, 32'd0);
    reset = 1'b0;
    step();

    // 1: pipeline write, one-cycle latency
    pl_regwrite = 1'b1; pl_wrreg = 5'd5; pl_wrdata = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    check("t1_regwrite", {31'd0, regwrite}, 32'd1);
    check("t1_pend", pend, 32'd0);
    idle_inputs();
    step();

    // 2: single buffered write, two-cycle latency
    lu_valid = 1'b1; lu_wrreg = 5'd9; lu_wrdata = 32'h1234;
    expect_wr(5'd9, 32'h1234);
    step();
    idle_inputs();
    check("t2_pend_set", pend, 32'h0000_0200);
    check("t2_no_write_yet", {31'd0, regwrite}, 32'd0);
    step();
    check("t2_regwrite", {31'd0, regwrite}, 32'd1);
    check("t2_pend_clear", pend, 32'd0);
    step();

    // 3: fill FIFO under a busy pipeline, starvation, then in-order drain
    for (int i = 0; i < 10; i++) begin
      pl_regwrite = 1'b1; pl_wrreg = 5'd20; pl_wrdata = 32'h2000_0000 + i;
      expect_wr(5'd20, 32'h2000_0000 + i);
      lu_valid  = (i < 5);
      lu_wrreg  = 5'(i + 1);
      lu_wrdata = 32'h100 + i + 1;
      step();
      if (i == 3) check("t3_full_after_4", {31'd0, lu_ready}, 32'd0);
      if (i == 4) check("t3_full_rejects", {31'd0, lu_ready}, 32'd0);
      if (i == 7) check("t3_stall_before", {31'd0, stall_req}, 32'd0);
      if (i == 8) check("t3_stall_at_8", {31'd0, stall_req}, 32'd1);
      if (i == 9) check("t3_stall_sat", {31'd0, stall_req}, 32'd1);
    end
    idle_inputs();
    check("t3_pend_full", pend, 32'h0000_001E);
    for (int r = 1; r <= 4; r++) expect_wr(5'(r), 32'h100 + r);
    step();
    check("t3_stall_drop", {31'd0, stall_req}, 32'd0);
    check("t3_ready_back", {31'd0, lu_ready}, 32'd1);
    step();
    step();
    step();
    check("t3_pend_empty", pend, 32'd0);
    step();

    // 4: WAW kill of a buffered entry, then a push killed in its own cycle
    lu_valid = 1'b1; lu_wrreg = 5'd7; lu_wrdata = 32'hAAAA;
    step();
    idle_inputs();
    check("t4_pend7", pend, 32'h0000_0080);
    pl_regwrite = 1'b1; pl_wrreg = 5'd7; pl_wrdata = 32'hBBBB;
    expect_wr(5'd7, 32'hBBBB);
    step();
    idle_inputs();
    check("t4_pend_killed", pend, 32'd0);
    step();
    check("t4_dead_pop_silent", {31'd0, regwrite}, 32'd0);
    check("t4_wrreg_hold", {27'd0, wrreg}, 32'd7);
    check("t4_wrdata_hold", wrdata, 32'hBBBB);
    pl_regwrite = 1'b1; pl_wrreg = 5'd11; pl_wrdata = 32'h1111;
    lu_valid = 1'b1; lu_wrreg = 5'd11; lu_wrdata = 32'h2222;
    expect_wr(5'd11, 32'h1111);
    step();
    idle_inputs();
    check("t4_push_dead_pend", pend, 32'd0);
    step();
    step();
    check("t4_cnt_kill", cnt_kill, STATS ? 32'd2 : 32'd0);
    check("t4_cnt_lu_wr", cnt_lu_wr, STATS ? 32'd5 : 32'd0);

    // 5: register 0 traffic is ignored; buffered entry drains in that slot
    lu_valid = 1'b1; lu_wrreg = 5'd12; lu_wrdata = 32'hC0C0;
    step();
    lu_valid = 1'b1; lu_wrreg = 5'd0; lu_wrdata = 32'h5555;
    pl_regwrite = 1'b1; pl_wrreg = 5'd0; pl_wrdata = 32'hFFFF;
    expect_wr(5'd12, 32'hC0C0);
    step();
    idle_inputs();
    check("t5_drain_in_r0_slot", {27'd0, wrreg}, 32'd12);
    check("t5_pend", pend, 32'd0);
    step();
    check("t5_no_r0_write", {31'd0, regwrite}, 32'd0);
    check("t5_cnt_lu_wr", cnt_lu_wr, STATS ? 32'd6 : 32'd0);

    // 6: reset discards three buffered entries
    for (int i = 0; i < 3; i++) begin
      pl_regwrite = 1'b1; pl_wrreg = 5'd22; pl_wrdata = 32'h2200 + i;
      expect_wr(5'd22, 32'h2200 + i);
      lu_valid = 1'b1; lu_wrreg = 5'(13 + i); lu_wrdata = 32'hE000 + i;
      step();
    end
    idle_inputs();
    check("t6_pend_before", pend, 32'h0000_E000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_regwrite", {31'd0, regwrite}, 32'd0);
    check("t6_wrreg", {27'd0, wrreg}, 32'd0);
    check("t6_wrdata", wrdata, 32'd0);
    check("t6_pend", pend, 32'd0);
    check("t6_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("t6_cnt_kill", cnt_kill, 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("t6_stall", {31'd0, stall_req}, 32'd0);

    check("sb_empty_at_end", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regwb_arb.md
Name: regwb_arb

Overview:
- Write-port arbiter in front of the CPU register memory.
- Merges the in-order pipeline writeback stream with results from long-latency units (multiply/divide, cache-miss loads) into the single write port (regwrite/wrreg/wrdata). It never stalls the pipeline stream.
- Long-latency results are buffered in a small FIFO and drained into idle write slots.
- Exports a pending-register mask for the hazard unit and a stall request if the FIFO starves.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- STARVE_MAX, 8: consecutive cycles the head may wait before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pl_regwrite  in  1  pipeline write request this cycle.
- pl_wrreg  in  5  pipeline destination register.
- pl_wrdata  in  32  pipeline write data.
- lu_valid  in  1  long-latency result valid.
- lu_wrreg  in  5  long-latency destination register.
- lu_wrdata  in  32  long-latency result data.
- lu_ready  out  1  FIFO can accept; equals !full.
- regwrite  out  1  registered write enable to register memory.
- wrreg  out  5  registered write address.
- wrdata  out  32  registered write data.
- pend  out  32  bit r=1 while a live buffered write targets r; bit 0 is always 0.
- stall_req  out  1  request the pipeline to idle its writeback.
- cnt_lu_wr  out  32  drained long-latency writes (see optional feature).
- cnt_kill  out  32  killed entries (see optional feature).

Behaviour:
- Reset (sync, on posedge with reset=1): FIFO empty, all live bits 0, starvation counter 0. Outputs: regwrite=0, wrreg=0, wrdata=0, pend=0, stall_req=0, counters 0. lu_ready=1 from the first cycle after reset. Reset mid-operation discards all buffered entries without writing them.
- Slot busy: the cycle is busy when pl_regwrite=1 and pl_wrreg!=0. Otherwise the slot is free.
- Busy cycle: next outputs are regwrite=1, wrreg=pl_wrreg, wrdata=pl_wrdata. Latency is 1 cycle.
- Free cycle, FIFO non-empty: pop the head.
  - Live head: next outputs are regwrite=1 with the head's reg and data.
  - Dead head: popped silently; regwrite=0 that cycle.
  - Only one pop per cycle.
- Free cycle, FIFO empty: regwrite=0. wrreg and wrdata hold their previous values.
- Push: an entry is enqueued when lu_valid && lu_ready.
  - lu_wrreg=0: accepted and discarded, no entry.
  - A pushed entry drains no earlier than the next cycle, so minimum lu-to-regwrite latency is 2 cycles.
  - Push and pop in the same cycle are allowed. lu_ready is computed before the pop, so a full FIFO does not accept even while popping.
- WAW kill: in a busy cycle, every live FIFO entry with reg==pl_wrreg is marked dead.
  - This includes an entry being pushed that same cycle with the same reg: it is enqueued dead.
  - Reason: the pipeline write is younger, so the older buffered value is never written.
- pend: combinational OR over live entries; it includes an entry the cycle after its push and clears the cycle after its pop.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - stall_req=1 while counter>=STARVE_MAX. It drops the cycle after the first pop.
  - Saturate the counter at STARVE_MAX.
- Pointers: pointers wrap mod DEPTH. Full/empty use an extra wrap bit.

Optional Feature:
- Macro: REGWB_STATS_EN.
- Defined:
  - cnt_lu_wr increments on each live pop.
  - cnt_kill increments by the number of entries marked dead each cycle, including entries enqueued dead.
  - Both counters are 32-bit and wrap at 2^32.
- Undefined: cnt_lu_wr and cnt_kill are tied to 0 and no counter logic is generated.

Test Plan:
1. Pipeline write reg 5=0xDEADBEEF with FIFO empty -> next cycle regwrite=1, wrreg=5, wrdata=0xDEADBEEF; pend=0.
2. lu push reg 9=0x1234 while pl idle -> pend[9]=1 next cycle; regwrite=1, wrreg=9, wrdata=0x1234 two cycles after push; pend[9]=0 afterward.
3. Push 4 entries (regs 1,2,3,4) with pl busy on reg 20 for 10 cycles -> lu_ready=0 after 4th; stall_req=1 after 8 non-popping cycles; after pl idles, writes drain in order 1,2,3,4, one per cycle.
4. Buffer reg 7=0xAAAA, then pl write reg 7=0xBBBB before drain -> pend[7] clears; only 0xBBBB written; no later write to 7; cnt_kill=1 with REGWB_STATS_EN.
5. lu push reg 0 and pl write reg 0 -> no FIFO entry, regwrite=0, pend=0; a concurrently buffered entry drains in that slot.
6. Assert reset with 3 entries buffered -> outputs 0, pend=0, lu_ready=1 next cycle; no buffered write ever appears.
